// File: rtl/apb_responder.sv
// apb_responder: APB register slave with an ID register, a CTRL register
// holding a programmable wait-state count, a free-running 64-bit cycle
// counter with a coherent high-word shadow, and four scratch registers.
//
// Handshake: a transfer is taken when psel and penable are both sampled high
// in IDLE. pready is a single-cycle registered pulse in the RESP state,
// and prdata/pslverr are only non-zero in that same cycle. If the master
// keeps penable high after the pulse, the slave parks in HOLD, so one
// access phase can never complete twice.
module apb_responder #(
   parameter logic [31:0] ID_VALUE   = 32'h4150_4231,
   parameter logic [3:0]  WAIT_RESET = 4'd0
) (
   input  logic        pclk,
   input  logic        preset,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] paddr,
   input  logic [31:0] pwdata,
   output logic        pready,
   output logic [31:0] prdata,
   output logic        pslverr
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;

   // captured transfer
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        wr_q;
   logic [3:0]  wcnt;

   // architectural registers
   logic [3:0]  wait_q;
   logic [31:0] scratch [4];
   logic [63:0] counter;
   logic [31:0] shadow;

   // decode of the transfer about to enter RESP
   logic        take_access;
   logic [31:0] cur_addr;
   logic        cur_wr;
   logic        cur_err;
   logic        enter_resp;
   logic        rd_ok;
   logic [31:0] rdata;
   logic [63:0] cnt_inc;

   // State register
   always_ff @(posedge pclk) begin
      if (preset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (psel && penable)
               state_nxt = (wait_q == 4'd0) ? ST_RESP : ST_WAIT;
         end
         ST_WAIT: begin
            // abort has priority over completion
            if (!psel || !penable)  state_nxt = ST_IDLE;
            else if (wcnt == 4'd1)  state_nxt = ST_RESP;
         end
         ST_RESP: begin
            state_nxt = penable ? ST_HOLD : ST_IDLE;
         end
         ST_HOLD: begin
            if (!penable) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output decode: error check and read mux for the transfer entering RESP.
   // In IDLE the transfer is seen directly on the bus (zero-wait case);
   // otherwise the captured copy is used.
   always_comb begin
      take_access = (state == ST_IDLE) && psel && penable;
      cur_addr    = take_access ? paddr  : addr_q;
      cur_wr      = take_access ? pwrite : wr_q;
      enter_resp  = (state_nxt == ST_RESP);
      cnt_inc     = counter + 64'd1;
      cur_err     = (cur_addr[31:5] != 27'd0) || (cur_addr[1:0] != 2'd0) ||
                    (cur_wr && ((cur_addr[4:2] == 3'd0) ||
                                (cur_addr[4:2] == 3'd2) ||
                                (cur_addr[4:2] == 3'd3)));
      rd_ok       = enter_resp && !cur_err && !cur_wr;
      rdata       = 32'd0;
      case (cur_addr[4:2])
         3'd0:    rdata = ID_VALUE;
         3'd1:    rdata = {28'd0, wait_q};
         // counter value as it will be during the RESP cycle
         3'd2:    rdata = cnt_inc[31:0];
         3'd3:    rdata = shadow;
         default: rdata = scratch[cur_addr[3:2]];
      endcase
   end

   // Transfer capture and wait-state countdown
   always_ff @(posedge pclk) begin
      if (preset) begin
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         wr_q    <= 1'b0;
         wcnt    <= 4'd0;
      end else if (take_access) begin
         addr_q  <= paddr;
         wdata_q <= pwdata;
         wr_q    <= pwrite;
         wcnt    <= wait_q;
      end else if (state == ST_WAIT) begin
         wcnt    <= wcnt - 4'd1;
      end
   end

   // Registered response outputs, valid only during RESP
   always_ff @(posedge pclk) begin
      if (preset) begin
         pready  <= 1'b0;
         prdata  <= 32'd0;
         pslverr <= 1'b0;
      end else begin
         pready  <= enter_resp;
         prdata  <= rd_ok ? rdata : 32'd0;
         pslverr <= enter_resp && cur_err;
      end
   end

   // Free-running counter; high word snapshot taken on a COUNT_LO read
   always_ff @(posedge pclk) begin
      if (preset) begin
         counter <= 64'd0;
         shadow  <= 32'd0;
      end else begin
         counter <= cnt_inc;
         if (rd_ok && (cur_addr[4:2] == 3'd2))
            shadow <= cnt_inc[63:32];
      end
   end

   // Register writes commit at the end of an error-free RESP cycle
   always_ff @(posedge pclk) begin
      if (preset) begin
         wait_q <= WAIT_RESET;
         for (int i = 0; i < 4; i++) scratch[i] <= 32'd0;
      end else if ((state == ST_RESP) && wr_q && !pslverr) begin
         case (addr_q[4:2])
            3'd1:    wait_q <= wdata_q[3:0];
            3'd4:    scratch[0] <= wdata_q;
            3'd5:    scratch[1] <= wdata_q;
            3'd6:    scratch[2] <= wdata_q;
            3'd7:    scratch[3] <= wdata_q;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_responder.sv
// Directed bench for apb_responder: register map, wait states, error
// responses, counter/shadow coherence, abort, HOLD behaviour and reset.
module tb_apb_responder;

   logic        pclk = 1'b0;
   logic        preset;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;

   int          total = 0;
   int          bad   = 0;
   longint      cyc   = 0;

   apb_responder dut (
      .pclk    (pclk),
      .preset  (preset),
      .psel    (psel),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .pready  (pready),
      .prdata  (prdata),
      .pslverr (pslverr)
   );

   // clock and cycle count
   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One APB transfer. lat = cycles from the first access-phase cycle to
   // pready (64 = timed out). extra = pready pulses seen after the first.
   task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input int hold, output logic [31:0] rd, output logic err,
                           output int lat, output int extra, output longint at);
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
      @(posedge pclk); #1;
      penable = 1'b1;
      lat = 0;
      @(negedge pclk);
      while (!pready && lat < 64) begin
         lat++;
         @(negedge pclk);
      end
      rd = prdata; err = pslverr; at = cyc; extra = 0;
      repeat (hold) begin
         @(negedge pclk);
         if (pready) extra++;
      end
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      repeat (2) begin
         @(negedge pclk);
         if (pready) extra++;
      end
   endtask

   task automatic wr_reg(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                         input int exp_lat, input logic exp_err);
      logic [31:0] rd; logic err; int lat, extra; longint at;
      apb_xfer(1'b1, addr, wd, 0, rd, err, lat, extra, at);
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_err"}, 64'(err), 64'(exp_err));
   endtask

   task automatic rd_reg(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                         input int exp_lat, input logic exp_err);
      logic [31:0] rd; logic err; int lat, extra; longint at;
      apb_xfer(1'b0, addr, 32'd0, 0, rd, err, lat, extra, at);
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_data"}, 64'(rd), 64'(exp_data));
      check({tag, "_err"}, 64'(err), 64'(exp_err));
   endtask

   // Write that is interrupted in its 2nd WAIT cycle, by dropping psel or by reset.
   task automatic interrupted_wr(input logic [31:0] addr, input logic [31:0] wd,
                                 input bit do_reset, output int pulses);
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = wd;
      @(posedge pclk); #1;
      penable = 1'b1;
      pulses = 0;
      @(negedge pclk); if (pready) pulses++;
      @(posedge pclk); #1;
      @(negedge pclk); if (pready) pulses++;
      @(posedge pclk); #1;
      if (do_reset) preset = 1'b1;
      else          psel   = 1'b0;
      @(negedge pclk); if (pready) pulses++;
      @(posedge pclk); #1;
      preset = 1'b0; psel = 1'b0; penable = 1'b0;
      repeat (10) begin
         @(negedge pclk);
         if (pready) pulses++;
      end
   endtask

   initial begin
      logic [31:0] rd, lo1, lo2, hi;
      logic        err;
      int          lat, extra, pulses;
      longint      at1, at2;

      // reset
      preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 32'd0; pwdata = 32'd0;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      check("rst_pready", 64'(pready), 64'd0);
      check("rst_prdata", 64'(prdata), 64'd0);
      check("rst_pslverr", 64'(pslverr), 64'd0);
      @(posedge pclk); #1;
      preset = 1'b0;

      // ID read with zero wait states
      rd_reg("id", 32'h00, 32'h4150_4231, 1, 1'b0);

      // wait states: CTRL write is not affected by itself, later ones are
      wr_reg("ctrl_w3", 32'h04, 32'h0000_0003, 1, 1'b0);
      wr_reg("scr0_w", 32'h10, 32'hDEAD_BEEF, 4, 1'b0);
      rd_reg("scr0_r", 32'h10, 32'hDEAD_BEEF, 4, 1'b0);
      rd_reg("ctrl_r", 32'h04, 32'h0000_0003, 4, 1'b0);
      wr_reg("ctrl_hi_ign", 32'h04, 32'hFFFF_FFF0, 4, 1'b0);
      rd_reg("ctrl_r0", 32'h04, 32'h0000_0000, 1, 1'b0);

      // error responses; the counter keeps counting through a COUNT_LO write
      apb_xfer(1'b0, 32'h08, 32'd0, 0, lo1, err, lat, extra, at1);
      wr_reg("ro_cnt_w", 32'h08, 32'h1234_5678, 1, 1'b1);
      wr_reg("ro_id_w", 32'h00, 32'h0000_0000, 1, 1'b1);
      rd_reg("oor_r", 32'h20, 32'h0, 1, 1'b1);
      rd_reg("unal_r", 32'h06, 32'h0, 1, 1'b1);
      apb_xfer(1'b0, 32'h08, 32'd0, 0, lo2, err, lat, extra, at2);
      check("cnt_delta", 64'(lo2 - lo1), 64'(32'(at2 - at1)));
      rd_reg("id_after_err", 32'h00, 32'h4150_4231, 1, 1'b0);

      // counter carry into the high word
      @(negedge pclk);
      force dut.counter = 64'h0000_0000_FFFF_FFFE;
      #1;
      release dut.counter;
      apb_xfer(1'b0, 32'h08, 32'd0, 0, lo1, err, lat, extra, at1);
      apb_xfer(1'b0, 32'h0C, 32'd0, 0, hi, err, lat, extra, at2);
      check("lo_small", 64'(lo1 < 32'd8), 64'd1);
      check("hi_coherent", 64'(hi), (lo1 >= 32'hFFFF_FFFE) ? 64'd0 : 64'd1);

      // abort during WAIT leaves the target untouched
      wr_reg("ctrl_w5", 32'h04, 32'h0000_0005, 1, 1'b0);
      wr_reg("scr2_w", 32'h18, 32'h1111_2222, 6, 1'b0);
      interrupted_wr(32'h18, 32'hBADB_AD00, 1'b0, pulses);
      check("abort_no_pready", 64'(pulses), 64'd0);
      rd_reg("scr2_keep", 32'h18, 32'h1111_2222, 6, 1'b0);

      // penable held after pready: one pulse only
      apb_xfer(1'b0, 32'h18, 32'd0, 3, rd, err, lat, extra, at1);
      check("hold_lat", 64'(lat), 64'd6);
      check("hold_data", 64'(rd), 64'h1111_2222);
      check("hold_extra", 64'(extra), 64'd0);

      // reset during WAIT abandons the write and restores all registers
      wr_reg("scr1_w", 32'h14, 32'hCAFE_F00D, 6, 1'b0);
      interrupted_wr(32'h1C, 32'h5555_5555, 1'b1, pulses);
      check("rst_wait_no_pready", 64'(pulses), 64'd0);
      rd_reg("rst_ctrl", 32'h04, 32'h0, 1, 1'b0);
      rd_reg("rst_scr0", 32'h10, 32'h0, 1, 1'b0);
      rd_reg("rst_scr1", 32'h14, 32'h0, 1, 1'b0);
      rd_reg("rst_scr2", 32'h18, 32'h0, 1, 1'b0);
      rd_reg("rst_scr3", 32'h1C, 32'h0, 1, 1'b0);
      rd_reg("rst_shadow", 32'h0C, 32'h0, 1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
